// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and funct3 encodings for the data-memory responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // RV32I load/store size encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Latched request; address is held at full 32-bit width and the
  // responder uses only the low DM_ADDRESS bits.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
// ============================================================================
// Module   : dmem_lane_fmt
// Purpose  : Combinational byte-lane formatter: load extraction/extension,
//            store lane shifting and byte enables, misalign/illegal flags.
// Config   : DMEM_MISALIGN_TRAP_EN - when undefined, halfword/word lanes are
//            forced to natural alignment before the access is formatted.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic        misalign,
  output logic        illegal
);

  logic        is_h;
  logic        is_w;
  logic [1:0]  lane;
  logic [31:0] rsh;

  // Decode size, pick the effective lane and format load/store data
  always_comb begin
    is_h     = (funct3 == F3_H) || (funct3 == F3_HU);
    is_w     = (funct3 == F3_W);
    misalign = (is_h && addr_lo[0]) || (is_w && (addr_lo != 2'b00));
    // Stores only have B/H/W; loads reject 011, 110 and 111
    if (we) illegal = (funct3 > F3_W);
    else    illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
    lane = addr_lo;
`else
    if (is_w)      lane = 2'b00;
    else if (is_h) lane = {addr_lo[1], 1'b0};
    else           lane = addr_lo;
`endif

    rsh = rword >> {lane, 3'b000};
    case (funct3)
      F3_B:    load_val = {{24{rsh[7]}}, rsh[7:0]};
      F3_H:    load_val = {{16{rsh[15]}}, rsh[15:0]};
      F3_W:    load_val = rsh;
      F3_BU:   load_val = {24'd0, rsh[7:0]};
      F3_HU:   load_val = {16'd0, rsh[15:0]};
      default: load_val = 32'd0;
    endcase

    case (funct3)
      F3_B:    byte_en = 4'b0001 << lane;
      F3_H:    byte_en = 4'b0011 << lane;
      F3_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    wword = wdata << {lane, 3'b000};
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : MEM-stage data-memory slave. One outstanding request, fixed
//            LATENCY from accept to a one-cycle response strobe.
// Config   : DMEM_MISALIGN_TRAP_EN - defined: misaligned accesses error out;
//            undefined: misaligned accesses are silently aligned.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

  dmem_state_e state;
  logic [3:0]  cnt;
  dmem_req_t   lat_req;
  dmem_req_t   in_req;
  dmem_req_t   op;
  logic        do_op;
  logic        op_err;
  logic [31:0] rword;
  logic [31:0] load_val;
  logic [3:0]  byte_en;
  logic [31:0] wword;
  logic        misalign;
  logic        illegal;
  logic [DM_ADDRESS-3:0] widx;

  logic [31:0] mem [0:DEPTH-1];

  // With LATENCY==1 the accept edge is also the RESP-entry edge, so the
  // operation must use the incoming request rather than the latched copy.
  always_comb begin
    in_req.we     = req_we;
    in_req.addr   = 32'(req_addr);
    in_req.wdata  = req_wdata;
    in_req.funct3 = req_funct3;
    op    = (state == IDLE) ? in_req : lat_req;
    do_op = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
            ((state == WAIT) && (cnt == 4'd1));
    widx  = op.addr[DM_ADDRESS-1:2];
    rword = mem[widx];
`ifdef DMEM_MISALIGN_TRAP_EN
    op_err = illegal || misalign;
`else
    op_err = illegal;
`endif
  end

  logic unused_sig;
  assign unused_sig = ^{op.addr[31:DM_ADDRESS], misalign};

  dmem_lane_fmt u_fmt (
    .we       (op.we),
    .funct3   (op.funct3),
    .addr_lo  (op.addr[1:0]),
    .rword    (rword),
    .wdata    (op.wdata),
    .load_val (load_val),
    .byte_en  (byte_en),
    .wword    (wword),
    .misalign (misalign),
    .illegal  (illegal)
  );

  // Store commit on the RESP-entry edge; a coincident reset suppresses it
  always_ff @(posedge clk) begin
    if (!reset && do_op && op.we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Request FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_req   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_req   <= in_req;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (do_op) begin
        rsp_valid <= 1'b1;
        rsp_err   <= op_err;
        rsp_rdata <= (op.we || op_err) ? '0 : load_val;
      end
    end
  end

endmodule

`default_nettype wire
